// File: rtl/hall_speed_estimator.sv
// Hall-sensor front end for a BLDC drive: synchronises and debounces the raw
// hall lines, tracks sector, direction and signed position, measures the
// clock count between consecutive same-direction sector steps, and flags
// stalls, illegal codes and skipped sectors.
module hall_speed_estimator #(
    parameter int unsigned CLK_FREQ_HZ   = 27_000_000,
    parameter int unsigned POS_WIDTH     = 32,
    parameter int unsigned PERIOD_WIDTH  = 24,
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned IDLE_MS       = 1000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              hall_raw,
    input  logic                    position_clear,
    output logic [2:0]              sector,
    output logic [1:0]              rotation_direction,
    output logic [POS_WIDTH-1:0]    position,
    output logic [PERIOD_WIDTH-1:0] period_ticks,
    output logic                    period_valid,
    output logic                    stalled,
    output logic                    illegal_fault,
    output logic                    skip_fault
);

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_CW   = 2'd1;
    localparam logic [1:0] DIR_CCW  = 2'd2;

    // Stall detection runs on its own counter so it works even when the idle
    // time exceeds the range of the saturating period timer.
    localparam longint unsigned IDLE_TICKS = longint'(CLK_FREQ_HZ) / 1000 * longint'(IDLE_MS);
    localparam int unsigned     IDLE_W     = $clog2(IDLE_TICKS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TICKS - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_TICKS);

    localparam int unsigned      CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;

    function automatic logic [2:0] code_to_sector(input logic [2:0] code);
        case (code)
            3'b101:  code_to_sector = 3'd0;
            3'b100:  code_to_sector = 3'd1;
            3'b110:  code_to_sector = 3'd2;
            3'b010:  code_to_sector = 3'd3;
            3'b011:  code_to_sector = 3'd4;
            3'b001:  code_to_sector = 3'd5;
            default: code_to_sector = 3'd7;
        endcase
    endfunction

    logic [2:0]              sync1_q, sync2_q;
    logic [2:0]              cand_q, cand_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              acc_q, acc_d;
    logic [2:0]              sector_q, sector_d;
    logic [1:0]              dir_q, dir_d;
    logic [POS_WIDTH-1:0]    pos_q, pos_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
    logic [IDLE_W-1:0]       idle_q, idle_d;
    logic                    pv_q, pv_d;
    logic                    stalled_q, stalled_d;
    logic                    ill_q, ill_d;
    logic                    skip_q, skip_d;
    // Set after a CW/CCW step; any other event breaks the streak so the
    // next step only re-establishes the timing reference.
    logic                    chain_q, chain_d;

    logic                    accept;
    logic [2:0]              new_sec;
    logic [3:0]              diff;
    logic [1:0]              step_dir;

    // Next-state: input filter, transition classification, timers, stall.
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sector_d  = sector_q;
        dir_d     = dir_q;
        pos_d     = pos_q;
        period_d  = period_q;
        chain_d   = chain_q;
        stalled_d = stalled_q;
        pv_d      = 1'b0;
        ill_d     = 1'b0;
        skip_d    = 1'b0;
        step_dir  = DIR_NONE;
        timer_d   = (timer_q == PERIOD_MAX) ? timer_q : timer_q + 1'b1;
        idle_d    = (idle_q == IDLE_SAT) ? idle_q : idle_q + 1'b1;

        // The candidate must be seen unchanged for FILTER_CYCLES compares
        // after it was loaded before it becomes the accepted code.
        accept  = (sync2_q == cand_q) && (cnt_q == CNT_LAST) && (cand_q != acc_q);
        new_sec = code_to_sector(cand_q);
        if (new_sec >= sector_q) begin
            diff = {1'b0, new_sec} - {1'b0, sector_q};
        end else begin
            diff = {1'b0, new_sec} + 4'd6 - {1'b0, sector_q};
        end

        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (accept) begin
            acc_d   = cand_q;
            timer_d = '0;
            idle_d  = '0;
            chain_d = 1'b0;
            if (new_sec == 3'd7) begin
                sector_d = 3'd7;
                ill_d    = 1'b1;
            end else if (sector_q == 3'd7) begin
                sector_d = new_sec;
            end else if (diff == 4'd1 || diff == 4'd5) begin
                step_dir  = (diff == 4'd1) ? DIR_CW : DIR_CCW;
                sector_d  = new_sec;
                dir_d     = step_dir;
                stalled_d = 1'b0;
                chain_d   = 1'b1;
                pos_d     = (diff == 4'd1) ? pos_q + 1'b1 : pos_q - 1'b1;
                if (chain_q && step_dir == dir_q) begin
                    pv_d     = 1'b1;
                    period_d = (timer_q == PERIOD_MAX) ? PERIOD_MAX : timer_q + 1'b1;
                end
            end else begin
                sector_d = new_sec;
                skip_d   = 1'b1;
            end
        end else if (idle_q == IDLE_LAST) begin
            stalled_d = 1'b1;
            dir_d     = DIR_NONE;
            period_d  = '0;
            chain_d   = 1'b0;
        end

        if (position_clear) begin
            pos_d = '0;
        end
    end

    // State registers, including the two-stage synchroniser on the hall lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 3'b000;
            sync2_q   <= 3'b000;
            cand_q    <= 3'b000;
            cnt_q     <= '0;
            acc_q     <= 3'b000;
            sector_q  <= 3'd7;
            dir_q     <= DIR_NONE;
            pos_q     <= '0;
            period_q  <= '0;
            timer_q   <= '0;
            idle_q    <= '0;
            pv_q      <= 1'b0;
            stalled_q <= 1'b1;
            ill_q     <= 1'b0;
            skip_q    <= 1'b0;
            chain_q   <= 1'b0;
        end else begin
            sync1_q   <= hall_raw;
            sync2_q   <= sync1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sector_q  <= sector_d;
            dir_q     <= dir_d;
            pos_q     <= pos_d;
            period_q  <= period_d;
            timer_q   <= timer_d;
            idle_q    <= idle_d;
            pv_q      <= pv_d;
            stalled_q <= stalled_d;
            ill_q     <= ill_d;
            skip_q    <= skip_d;
            chain_q   <= chain_d;
        end
    end

    assign sector             = sector_q;
    assign rotation_direction = dir_q;
    assign position           = pos_q;
    assign period_ticks       = period_q;
    assign period_valid       = pv_q;
    assign stalled            = stalled_q;
    assign illegal_fault      = ill_q;
    assign skip_fault         = skip_q;

endmodule

// File: tb/tb_hall_speed_estimator.sv
// Bench for hall_speed_estimator: directed table, corner sequences and a
// randomised run, all cross-checked every cycle against a behavioural model.
module tb_hall_speed_estimator;

    logic        clk;
    logic        reset_n;
    logic [2:0]  hall_raw;
    logic        position_clear;
    logic [2:0]  sector;
    logic [1:0]  rotation_direction;
    logic [31:0] position;
    logic [23:0] period_ticks;
    logic        period_valid;
    logic        stalled;
    logic        illegal_fault;
    logic        skip_fault;

    hall_speed_estimator #(
        .CLK_FREQ_HZ  (1_000_000),
        .POS_WIDTH    (32),
        .PERIOD_WIDTH (24),
        .FILTER_CYCLES(4),
        .IDLE_MS      (1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .hall_raw          (hall_raw),
        .position_clear    (position_clear),
        .sector            (sector),
        .rotation_direction(rotation_direction),
        .position          (position),
        .period_ticks      (period_ticks),
        .period_valid      (period_valid),
        .stalled           (stalled),
        .illegal_fault     (illegal_fault),
        .skip_fault        (skip_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    // Raw samples taken at each edge; a code is accepted at edge n when the
    // samples from edges n-6..n-2 (two-stage sync delay, FILTER+1 samples)
    // all agree and differ from the last accepted code.
    localparam int IDLE = 1000;
    int          sec_lut [8] = '{7, 5, 3, 4, 1, 0, 2, 7};
    logic [2:0]  samples[$];
    logic [2:0]  m_acc;
    int          m_sector, m_dir, m_period, m_n, m_last;
    logic [31:0] m_pos;
    bit          m_pv, m_stalled, m_ill, m_skip, m_chain;

    task automatic model_reset();
        samples.delete();
        for (int i = 0; i < 8; i++) samples.push_back(3'b000);
        m_acc = 3'b000; m_sector = 7; m_dir = 0; m_pos = '0; m_period = 0;
        m_pv = 0; m_stalled = 1; m_ill = 0; m_skip = 0; m_chain = 0;
        m_n = 0; m_last = 0;
    endtask

    task automatic model_edge(input logic [2:0] raw, input bit clr);
        int s, ns, d, sd;
        bit stable;
        logic [2:0] v;
        m_n++;
        samples.push_back(raw);
        s = samples.size();
        v = samples[s-3];
        stable = 1;
        for (int k = s - 7; k <= s - 3; k++) if (samples[k] != v) stable = 0;
        m_pv = 0; m_ill = 0; m_skip = 0;
        if (stable && v != m_acc) begin
            m_acc = v;
            ns = sec_lut[v];
            if (ns == 7) begin
                m_sector = 7; m_ill = 1; m_chain = 0;
            end else if (m_sector == 7) begin
                m_sector = ns; m_chain = 0;
            end else begin
                d = (ns - m_sector + 6) % 6;
                if (d == 1 || d == 5) begin
                    sd = (d == 1) ? 1 : 2;
                    if (m_chain && sd == m_dir) begin
                        m_pv = 1; m_period = m_n - m_last;
                    end
                    m_pos = (d == 1) ? m_pos + 32'd1 : m_pos - 32'd1;
                    m_dir = sd; m_stalled = 0; m_chain = 1; m_sector = ns;
                end else begin
                    m_skip = 1; m_chain = 0; m_sector = ns;
                end
            end
            m_last = m_n;
        end else if (m_n - m_last == IDLE) begin
            m_stalled = 1; m_dir = 0; m_period = 0; m_chain = 0;
        end
        if (clr) m_pos = '0;
        if (samples.size() > 32) void'(samples.pop_front());
    endtask

    int pv_cnt, skip_cnt, ill_cnt;

    // One clock: drive inputs, advance model at the edge, compare just after.
    task automatic tick(input logic [2:0] code, input bit clr);
        logic [64:0] got, want;
        hall_raw       = code;
        position_clear = clr;
        @(posedge clk);
        model_edge(code, clr);
        #1;
        got  = {sector, rotation_direction, position, period_ticks,
                period_valid, stalled, illegal_fault, skip_fault};
        want = {3'(m_sector), 2'(m_dir), m_pos, 24'(m_period), m_pv, m_stalled, m_ill, m_skip};
        chk("model_state", {63'b0, got}, {63'b0, want});
        pv_cnt   += int'(period_valid);
        skip_cnt += int'(skip_fault);
        ill_cnt  += int'(illegal_fault);
    endtask

    typedef struct {
        logic [2:0]  code;
        bit          clr;
        int          hold;
        int          sector;
        int          dir;
        logic [31:0] pos;
        int          period;
        int          pv;
        int          skip;
        int          ill;
        int          stalled;
    } vec_t;

    vec_t tbl[17];

    initial begin
        //            code  clr hold  sec dir pos           per  pv sk il st
        tbl[0]  = '{3'b101, 0, 200,  0, 0, 32'h0,        0,   0, 0, 0, 1};
        tbl[1]  = '{3'b100, 0, 200,  1, 1, 32'h1,        0,   0, 0, 0, 0};
        tbl[2]  = '{3'b110, 0, 200,  2, 1, 32'h2,        200, 1, 0, 0, 0};
        tbl[3]  = '{3'b010, 0, 200,  3, 1, 32'h3,        200, 1, 0, 0, 0};
        tbl[4]  = '{3'b011, 0, 2,    3, 1, 32'h3,        200, 0, 0, 0, 0};
        tbl[5]  = '{3'b010, 0, 200,  3, 1, 32'h3,        200, 0, 0, 0, 0};
        tbl[6]  = '{3'b110, 0, 200,  2, 2, 32'h2,        200, 0, 0, 0, 0};
        tbl[7]  = '{3'b100, 0, 200,  1, 2, 32'h1,        200, 1, 0, 0, 0};
        tbl[8]  = '{3'b010, 0, 200,  3, 2, 32'h1,        200, 0, 1, 0, 0};
        tbl[9]  = '{3'b011, 0, 200,  4, 1, 32'h2,        200, 0, 0, 0, 0};
        tbl[10] = '{3'b010, 0, 200,  3, 2, 32'h1,        200, 0, 0, 0, 0};
        tbl[11] = '{3'b111, 0, 200,  7, 2, 32'h1,        200, 0, 0, 1, 0};
        tbl[12] = '{3'b010, 0, 1100, 3, 0, 32'h1,        0,   0, 0, 0, 1};
        tbl[13] = '{3'b110, 0, 200,  2, 2, 32'h0,        0,   0, 0, 0, 0};
        tbl[14] = '{3'b100, 0, 200,  1, 2, 32'hFFFFFFFF, 200, 1, 0, 0, 0};
        tbl[15] = '{3'b100, 1, 10,   1, 2, 32'h0,        200, 0, 0, 0, 0};
        tbl[16] = '{3'b101, 0, 200,  0, 2, 32'hFFFFFFFF, 210, 1, 0, 0, 0};

        reset_n = 1'b0; hall_raw = 3'b000; position_clear = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_sector", sector, 7);
        chk("reset_dir", rotation_direction, 0);
        chk("reset_pos", position, 0);
        chk("reset_period", period_ticks, 0);
        chk("reset_stalled", stalled, 1);
        chk("reset_pulses", {period_valid, illegal_fault, skip_fault}, 0);
        reset_n = 1'b1;
        model_reset();

        // Raw-to-output latency is FILTER_CYCLES+3 = 7 clocks.
        for (int c = 0; c < 6; c++) tick(3'b101, 0);
        chk("latency_before", sector, 7);
        tick(3'b101, 0);
        chk("latency_at7", sector, 0);

        for (int e = 0; e < 17; e++) begin
            pv_cnt = 0; skip_cnt = 0; ill_cnt = 0;
            for (int c = 0; c < tbl[e].hold; c++) tick(tbl[e].code, (c == 0) ? tbl[e].clr : 1'b0);
            chk("tbl_sector", sector, tbl[e].sector);
            chk("tbl_dir", rotation_direction, tbl[e].dir);
            chk("tbl_pos", position, tbl[e].pos);
            chk("tbl_period", period_ticks, tbl[e].period);
            chk("tbl_stalled", stalled, tbl[e].stalled);
            chk("tbl_pv_count", pv_cnt, tbl[e].pv);
            chk("tbl_skip_count", skip_cnt, tbl[e].skip);
            chk("tbl_ill_count", ill_cnt, tbl[e].ill);
            $display("entry %0d code=%b hold=%0d sector=%0d dir=%0d pos=%0h period=%0d",
                     e, tbl[e].code, tbl[e].hold, sector, rotation_direction, position, period_ticks);
        end

        // position_clear on the same edge as a CCW step: clear wins.
        for (int c = 0; c < 6; c++) tick(3'b001, 0);
        tick(3'b001, 1);
        chk("clr_step_sector", sector, 5);
        chk("clr_step_pos", position, 0);
        chk("clr_step_pv", period_valid, 1);
        chk("clr_step_period", period_ticks, 200);
        $display("clear+step sector=%0d pos=%0h", sector, position);

        // Accepted change lands exactly on the stall threshold: no stall.
        for (int c = 0; c < 993; c++) tick(3'b001, 0);
        for (int c = 0; c < 7; c++) tick(3'b011, 0);
        chk("stall_tie_stalled", stalled, 0);
        chk("stall_tie_sector", sector, 4);
        chk("stall_tie_pos", position, 32'hFFFFFFFF);
        chk("stall_tie_period", period_ticks, 1000);
        for (int c = 0; c < 5; c++) tick(3'b011, 0);
        chk("stall_tie_after", stalled, 0);
        $display("stall tie stalled=%b period=%0d", stalled, period_ticks);

        // Asynchronous reset in the middle of filtering a new code.
        for (int c = 0; c < 3; c++) tick(3'b110, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_sector", sector, 7);
        chk("midrst_pos", position, 0);
        chk("midrst_dir", rotation_direction, 0);
        chk("midrst_period", period_ticks, 0);
        chk("midrst_stalled", stalled, 1);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        model_reset();
        for (int c = 0; c < 6; c++) tick(3'b110, 0);
        chk("postrst_refilter", sector, 7);
        tick(3'b110, 0);
        chk("postrst_sector", sector, 2);
        chk("postrst_dir", rotation_direction, 0);
        $display("mid-filter reset sector=%0d", sector);

        // Random hall activity: glitches, steps, skips, illegal codes, stalls.
        for (int seg = 0; seg < 300; seg++) begin
            logic [2:0] code;
            int r, hold;
            bit clr;
            code = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 19);
            hold = (r < 14) ? $urandom_range(1, 12) : ((r < 19) ? $urandom_range(150, 250) : 1005);
            clr = ($urandom_range(0, 15) == 0);
            for (int c = 0; c < hold; c++) tick(code, (c == 0) ? clr : 1'b0);
            $display("rand %0d code=%b hold=%0d sector=%0d pos=%0h", seg, code, hold, sector, position);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
